// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: op codes, HD44780 instruction
// bytes, delay constants and the sequencer state encoding.
package lcd_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_INIT    = 3'd1;
  localparam logic [2:0] OP_CONFIG  = 3'd2;
  localparam logic [2:0] OP_WRITE   = 3'd3;
  localparam logic [2:0] OP_CLEAR   = 3'd4;
  localparam logic [2:0] OP_HOME    = 3'd5;
  localparam logic [2:0] OP_SET_POS = 3'd6;
  localparam logic [2:0] OP_OFF     = 3'd7;

  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_DISP_OFF  = 8'h08;
  localparam logic [7:0] LCD_FUNC_BASE = 8'h20;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

  localparam int unsigned T_PWR_US   = 15000;
  localparam int unsigned T_SHORT_US = 42;
  localparam int unsigned T_LONG_US  = 1640;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWR_WAIT,
    S_ISSUE,
    S_DRV_WAIT,
    S_EXEC_WAIT
  } state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       long_dly;
  } lcd_xfer_t;

  function automatic lcd_xfer_t op_xfer(input logic [2:0] op, input logic [7:0] arg,
                                        input logic lines2);
    lcd_xfer_t x;
    x = '{rs: 1'b0, data: LCD_DISP_OFF, long_dly: 1'b0};
    case (op)
      OP_CONFIG:  x.data = LCD_DISP_OFF | {5'b0, arg[2:0]};
      OP_WRITE:   begin x.rs = 1'b1; x.data = arg; end
      OP_CLEAR:   begin x.data = LCD_CLEAR; x.long_dly = 1'b1; end
      OP_HOME:    begin x.data = LCD_HOME; x.long_dly = 1'b1; end
      OP_SET_POS: x.data = LCD_SET_DDRAM | {1'b0, lines2 & arg[6], 2'b00, arg[3:0]};
      default:    x.data = LCD_DISP_OFF;
    endcase
    return x;
  endfunction

  function automatic lcd_xfer_t init_xfer(input logic [1:0] step, input logic dl,
                                          input logic lines2);
    lcd_xfer_t x;
    x = '{rs: 1'b0, data: LCD_CLEAR, long_dly: 1'b0};
    case (step)
      2'd0:    x.data = LCD_FUNC_BASE | {3'b0, dl, lines2, 3'b000};
      2'd1:    x.data = LCD_ENTRY;
      2'd2:    x.data = LCD_DISP_ON;
      default: x.long_dly = 1'b1;
    endcase
    return x;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Down-counting cycle timer; done is high on the final cycle of a loaded count.
module lcd_delay_timer #(
  parameter int CLK_HZ = 50_000_000,
  parameter int MAX_US = 15000,
  localparam int W = $clog2(MAX_US * (CLK_HZ / 1_000_000) + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_cycles,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_cycles;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Accepts high-level LCD operations and sequences instruction/data bytes to the
// bus driver, timing each instruction's execution with an internal cycle timer.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter bit DL_8BIT = 1'b0,
  parameter bit LINES2  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic       drv_valid,
  output logic       drv_rs,
  output logic [7:0] drv_byte,
  input  logic       drv_done,
  output logic       busy,
  output logic       init_done,
  output logic       error
);

  localparam int unsigned CYC_US = CLK_HZ / 1_000_000;
  localparam int TW = $clog2(T_PWR_US * CYC_US + 1);
  localparam logic [TW-1:0] CYC_PWR   = TW'(T_PWR_US * CYC_US);
  localparam logic [TW-1:0] CYC_SHORT = TW'(T_SHORT_US * CYC_US);
  localparam logic [TW-1:0] CYC_LONG  = TW'(T_LONG_US * CYC_US);

  state_t      state;
  logic [1:0]  step;
  logic        in_init;
  logic        long_dly;
  logic        accept;
  logic        tmr_load;
  logic        tmr_done;
  logic [TW-1:0] tmr_cycles;
  lcd_xfer_t   op_x;
  lcd_xfer_t   init_x;

  assign accept = cmd_valid & cmd_ready;
  assign busy   = ~cmd_ready;
  assign op_x   = op_xfer(cmd_op, cmd_arg, LINES2);

  always_comb begin
    init_x = init_xfer((state == S_PWR_WAIT) ? 2'd0 : step + 2'd1, DL_8BIT, LINES2);
  end

  // Timer is loaded once for the power-up wait and once per completed byte.
  always_comb begin
    tmr_load   = ((state == S_IDLE) && accept && (cmd_op == OP_INIT)) ||
                 ((state == S_DRV_WAIT) && drv_done);
    tmr_cycles = CYC_SHORT;
    if (state == S_IDLE)
      tmr_cycles = CYC_PWR;
    else if (long_dly)
      tmr_cycles = CYC_LONG;
  end

  lcd_delay_timer #(
    .CLK_HZ (CLK_HZ),
    .MAX_US (T_PWR_US)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (tmr_load),
    .load_cycles (tmr_cycles),
    .done        (tmr_done)
  );

  // drv_valid is raised on every transition into ISSUE so the byte is presented there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= 2'd0;
      in_init   <= 1'b0;
      long_dly  <= 1'b0;
      cmd_ready <= 1'b1;
      drv_valid <= 1'b0;
      drv_rs    <= 1'b0;
      drv_byte  <= 8'h00;
      init_done <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (cmd_op == OP_INIT) begin
              init_done <= 1'b0;
              error     <= 1'b0;
              step      <= 2'd0;
              in_init   <= 1'b1;
              cmd_ready <= 1'b0;
              state     <= S_PWR_WAIT;
            end else if (cmd_op != OP_NOP) begin
              if (!init_done) begin
                error <= 1'b1;
              end else begin
                in_init   <= 1'b0;
                long_dly  <= op_x.long_dly;
                drv_valid <= 1'b1;
                drv_rs    <= op_x.rs;
                drv_byte  <= op_x.data;
                cmd_ready <= 1'b0;
                state     <= S_ISSUE;
              end
            end
          end
        end
        S_PWR_WAIT: begin
          if (tmr_done) begin
            step      <= 2'd0;
            long_dly  <= init_x.long_dly;
            drv_valid <= 1'b1;
            drv_rs    <= init_x.rs;
            drv_byte  <= init_x.data;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_DRV_WAIT;
        S_DRV_WAIT: begin
          if (drv_done) begin
            drv_valid <= 1'b0;
            state     <= S_EXEC_WAIT;
          end
        end
        S_EXEC_WAIT: begin
          if (tmr_done) begin
            if (in_init && (step != 2'd3)) begin
              step      <= step + 2'd1;
              long_dly  <= init_x.long_dly;
              drv_valid <= 1'b1;
              drv_rs    <= init_x.rs;
              drv_byte  <= init_x.data;
              state     <= S_ISSUE;
            end else begin
              if (in_init)
                init_done <= 1'b1;
              in_init   <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      if (drv_done && (state != S_DRV_WAIT))
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer at 1 MHz; a second instance with LINES2=0
// shares all inputs and is checked for the single-line SET_POS mapping.
module tb_lcd_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       drv_done;
  logic       cmd_ready, drv_valid, drv_rs, busy, init_done, error;
  logic [7:0] drv_byte;
  logic       cmd_ready_b, drv_valid_b, drv_rs_b, busy_b, init_done_b, error_b;
  logic [7:0] drv_byte_b;

  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  lcd_cmd_sequencer #(.CLK_HZ(1_000_000), .DL_8BIT(1'b0), .LINES2(1'b1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .drv_valid(drv_valid), .drv_rs(drv_rs),
    .drv_byte(drv_byte), .drv_done(drv_done), .busy(busy), .init_done(init_done),
    .error(error)
  );

  lcd_cmd_sequencer #(.CLK_HZ(1_000_000), .DL_8BIT(1'b0), .LINES2(1'b0)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .drv_valid(drv_valid_b), .drv_rs(drv_rs_b),
    .drv_byte(drv_byte_b), .drv_done(drv_done), .busy(busy_b), .init_done(init_done_b),
    .error(error_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called while drv_valid is high; acknowledges the byte and returns the number
  // of cycles afterwards spent busy with drv_valid low (bounded).
  task automatic complete_byte(output int n);
    tick();
    drv_done = 1'b1;
    tick();
    drv_done = 1'b0;
    n = 0;
    while (drv_valid == 1'b0 && busy == 1'b1 && n < 20000) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 8'h00; drv_done = 1'b0;
    repeat (3) tick();
    check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    check_cnt++; if (drv_valid !== 1'b0) $display("FAIL reset_drv_valid got %b want 0", drv_valid); else pass_cnt++;
    check_cnt++; if (drv_byte !== 8'h00 || drv_rs !== 1'b0) $display("FAIL reset_drv_byte got %h/%b want 00/0", drv_byte, drv_rs); else pass_cnt++;
    check_cnt++; if (init_done !== 1'b0 || error !== 1'b0) $display("FAIL reset_flags got init=%b err=%b want 0/0", init_done, error); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_op_before_init();
    send_cmd(3'd3, 8'h41);
    check_cnt++; if (error !== 1'b1) $display("FAIL early_write_error got %b want 1", error); else pass_cnt++;
    check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL early_write_ready got %b want 1", cmd_ready); else pass_cnt++;
    repeat (3) tick();
    check_cnt++; if (drv_valid !== 1'b0) $display("FAIL early_write_drv got %b want 0", drv_valid); else pass_cnt++;
  endtask

  task automatic test_init();
    logic [7:0] exp_byte [4];
    int exp_gap [4];
    int bad;
    int gap;
    exp_byte = '{8'h28, 8'h06, 8'h0C, 8'h01};
    exp_gap  = '{42, 42, 42, 1640};
    send_cmd(3'd1, 8'h00);
    check_cnt++; if (error !== 1'b0) $display("FAIL init_clears_error got %b want 0", error); else pass_cnt++;
    check_cnt++; if (busy !== 1'b1 || init_done !== 1'b0) $display("FAIL init_accept got busy=%b init=%b want 1/0", busy, init_done); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 15000; i++) begin
      if (drv_valid !== 1'b0) bad++;
      tick();
    end
    check_cnt++; if (bad != 0) $display("FAIL pwr_wait_quiet got %0d early cycles want 0", bad); else pass_cnt++;
    for (int s = 0; s < 4; s++) begin
      check_cnt++;
      if (drv_valid !== 1'b1 || drv_rs !== 1'b0 || drv_byte !== exp_byte[s])
        $display("FAIL init_step%0d_byte got v=%b rs=%b %h want 1/0/%h", s, drv_valid, drv_rs, drv_byte, exp_byte[s]);
      else pass_cnt++;
      complete_byte(gap);
      check_cnt++; if (gap != exp_gap[s]) $display("FAIL init_step%0d_delay got %0d want %0d", s, gap, exp_gap[s]); else pass_cnt++;
    end
    check_cnt++; if (init_done !== 1'b1 || cmd_ready !== 1'b1) $display("FAIL init_done got init=%b ready=%b want 1/1", init_done, cmd_ready); else pass_cnt++;
  endtask

  task automatic test_write_clear();
    int gap;
    send_cmd(3'd3, 8'h48);
    check_cnt++; if (drv_valid !== 1'b1 || drv_rs !== 1'b1 || drv_byte !== 8'h48) $display("FAIL write_byte got v=%b rs=%b %h want 1/1/48", drv_valid, drv_rs, drv_byte); else pass_cnt++;
    complete_byte(gap);
    check_cnt++; if (gap != 42) $display("FAIL write_busy got %0d want 42", gap); else pass_cnt++;
    check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL write_ready got %b want 1", cmd_ready); else pass_cnt++;
    send_cmd(3'd4, 8'h00);
    check_cnt++; if (drv_rs !== 1'b0 || drv_byte !== 8'h01) $display("FAIL clear_byte got rs=%b %h want 0/01", drv_rs, drv_byte); else pass_cnt++;
    complete_byte(gap);
    check_cnt++; if (gap != 1640) $display("FAIL clear_busy got %0d want 1640", gap); else pass_cnt++;
  endtask

  task automatic test_mapping();
    logic [2:0] ops  [4];
    logic [7:0] args [4];
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    int exp_gap [4];
    int gap;
    ops     = '{3'd6, 3'd2, 3'd7, 3'd5};
    args    = '{8'h45, 8'h07, 8'h00, 8'h00};
    exp_a   = '{8'hC5, 8'h0F, 8'h08, 8'h02};
    exp_b   = '{8'h85, 8'h0F, 8'h08, 8'h02};
    exp_gap = '{42, 42, 42, 1640};
    for (int k = 0; k < 4; k++) begin
      send_cmd(ops[k], args[k]);
      check_cnt++; if (drv_rs !== 1'b0 || drv_byte !== exp_a[k]) $display("FAIL map_op%0d got rs=%b %h want 0/%h", ops[k], drv_rs, drv_byte, exp_a[k]); else pass_cnt++;
      check_cnt++; if (drv_byte_b !== exp_b[k]) $display("FAIL map1line_op%0d got %h want %h", ops[k], drv_byte_b, exp_b[k]); else pass_cnt++;
      complete_byte(gap);
      check_cnt++; if (gap != exp_gap[k]) $display("FAIL map_op%0d_delay got %0d want %0d", ops[k], gap, exp_gap[k]); else pass_cnt++;
    end
  endtask

  task automatic test_stall_spurious();
    int bad;
    int gap;
    send_cmd(3'd3, 8'h5A);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (drv_valid !== 1'b1 || drv_rs !== 1'b1 || drv_byte !== 8'h5A) bad++;
      tick();
    end
    check_cnt++; if (bad != 0) $display("FAIL stall_stable got %0d unstable cycles want 0", bad); else pass_cnt++;
    complete_byte(gap);
    check_cnt++; if (gap != 42 || error !== 1'b0) $display("FAIL stall_finish got gap=%0d err=%b want 42/0", gap, error); else pass_cnt++;
    drv_done = 1'b1;
    tick();
    drv_done = 1'b0;
    check_cnt++; if (error !== 1'b1) $display("FAIL spurious_done_error got %b want 1", error); else pass_cnt++;
    check_cnt++; if (cmd_ready !== 1'b1 || drv_valid !== 1'b0) $display("FAIL spurious_done_idle got ready=%b v=%b want 1/0", cmd_ready, drv_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_init();
    int gap;
    int n;
    send_cmd(3'd1, 8'h00);
    check_cnt++; if (init_done !== 1'b0) $display("FAIL reinit_clears_done got %b want 0", init_done); else pass_cnt++;
    n = 0;
    while (drv_valid !== 1'b1 && n < 20000) begin n++; tick(); end
    check_cnt++; if (n != 15000) $display("FAIL reinit_pwr got %0d want 15000", n); else pass_cnt++;
    complete_byte(gap);
    complete_byte(gap);
    check_cnt++; if (drv_byte !== 8'h0C) $display("FAIL reinit_step2_byte got %h want 0C", drv_byte); else pass_cnt++;
    tick();
    drv_done = 1'b1;
    tick();
    drv_done = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check_cnt++; if (drv_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL midrst_handshake got v=%b ready=%b busy=%b want 0/1/0", drv_valid, cmd_ready, busy); else pass_cnt++;
    check_cnt++; if (init_done !== 1'b0 || error !== 1'b0 || drv_byte !== 8'h00 || drv_rs !== 1'b0) $display("FAIL midrst_state got init=%b err=%b byte=%h rs=%b want 0/0/00/0", init_done, error, drv_byte, drv_rs); else pass_cnt++;
    rst = 1'b0;
    tick();
    repeat (100) tick();
    check_cnt++; if (drv_valid !== 1'b0 || init_done !== 1'b0) $display("FAIL midrst_quiet got v=%b init=%b want 0/0", drv_valid, init_done); else pass_cnt++;
    test_init();
  endtask

  initial begin
    test_reset();
    test_op_before_init();
    test_init();
    test_write_clear();
    test_mapping();
    test_stall_spurious();
    test_reset_mid_init();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
